local_history_table: RTL
========================

// Module: local_history_table
// PURPOSE
//  Per-branch local history table (LHT) feeding the pattern history table.
//  Fetch PC indexes a 1024x10b history array; the registered history is the PHT read index.
//  At commit, the pre-update history is returned as the PHT write index.
//  The committed direction is then shifted into the entry.
//  An init FSM clears the array after reset, one entry per cycle.
// PARAMETERS
//  LHT_ENTRIES   1024  number of history entries
//  LOG_ENTRIES   10    log2(LHT_ENTRIES); index = pc[LOG_ENTRIES+1:2]
//  HIST_WIDTH    10    bits of history per entry (= PHT index width)
//  PC_WIDTH      64    PC width
// PORTS
//  clock              in   1           single clock; all state on posedge
//  reset              in   1           synchronous, active-high reset
//  lht_rd_valid_i     in   1           fetch lookup request
//  lht_rd_pc_i        in   PC_WIDTH    fetch PC of lookup
//  lht_hist_valid_o   out  1           lht_hist_o valid (1-cycle latency)
//  lht_hist_o         out  HIST_WIDTH  local history -> PHT read index
//  lht_cm_we_i        in   1           retired conditional branch update
//  lht_cm_pc_i        in   PC_WIDTH    PC of retired branch
//  lht_cm_brdir_i     in   1           resolved direction, 1 = taken
//  lht_cm_valid_o     out  1           lht_cm_index_o valid (1-cycle latency)
//  lht_cm_index_o     out  HIST_WIDTH  pre-update history -> PHT write index
//  lht_busy_o         out  1           init in progress; lookups/updates ignored
// BEHAVIOUR
//  One clock, clock. Reset is synchronous and active-high.
//  Reset values: lht_hist_valid_o=0, lht_hist_o=0, lht_cm_valid_o=0, lht_cm_index_o=0.
//  Reset also sets lht_busy_o=1, FSM=INIT, init_cnt=0.
//  FSM INIT:
//   - Write entry[init_cnt]=0 each cycle, then init_cnt++.
//   - After the write to LHT_ENTRIES-1, go to RUN; busy is 0 from the next cycle.
//   - Init takes exactly LHT_ENTRIES cycles after reset deasserts.
//   - In INIT, rd and cm requests are dropped: no valid outputs, no table write.
//  FSM RUN stays in RUN; only reset leaves it.
//  Reset asserted mid-INIT or in RUN: restart INIT from 0 on the next edge.
//   - Outputs return to their reset values.
//   - Requests in flight are discarded.
//  Lookup, for rd_valid_i in cycle N:
//   - Index ri = rd_pc[LOG_ENTRIES+1:2].
//   - In N+1: hist_valid_o=1 and hist_o = entry[ri] as defined below.
//   - rd_valid_i=0 gives hist_valid_o=0 in N+1; hist_o holds its last value.
//  Commit, for cm_we_i in cycle N:
//   - Index ci = cm_pc[LOG_ENTRIES+1:2]; old = entry[ci].
//   - In N+1: cm_valid_o=1 and cm_index_o = old.
//   - At edge N->N+1: entry[ci] <= {old[HIST_WIDTH-2:0], brdir}.
//  Same-cycle rd and cm with ri==ci: write-first bypass; hist_o = new (post-shift) value.
//  Same-cycle rd and cm with ri!=ci: independent, no interaction.
//  Back-to-back commits to one index: second sees first's shifted value.
//  The array is updated at the edge, so no extra forwarding is needed.
//  History arithmetic is a pure shift; bit 0 is the newest direction.
//  The oldest bit drops off; there is no saturation or wrap state.
//  PC bits outside [LOG_ENTRIES+1:2] are ignored (aliasing permitted).
//  Array is reg-based (no memory macro) and has no reset port; cleared only via INIT.
// TESTING
//  1. Reset 1 cycle, then release.
//     -> busy=1 for exactly 1024 cycles, then 0.
//     -> Any rd/cm during busy: no valid outputs.
//  2. After init, rd pc=0x1000 (index 0x000).
//     -> Next cycle hist_valid_o=1, hist_o=10'h000.
//  3. Commits pc=0x1004 dirs 1,1,0,1 on consecutive cycles.
//     -> cm_index_o = 000,001,003,006.
//     -> A later rd of 0x1004 returns 10'h00D.
//  4. Same cycle rd and cm pc=0x2008 dir=1, entry=10'h3FF.
//     -> hist_o=10'h3FF (bypass), cm_index_o=10'h3FF.
//  5. Alias: commit pc=0x0010 dir=1, then rd pc=0x1010.
//     -> hist_o=10'h001 (same index 4).
//  6. Reset asserted mid-RUN with cm_we_i=1.
//     -> Entry not written; all outputs return to reset values.
//     -> Full 1024-cycle re-init follows; entry reads 0.

Source files
------------

// File: rtl/local_history_table.sv
`default_nettype none
// ============================================================================
//  Module      : local_history_table
//  Description : Per-branch local history table. The fetch PC selects a
//                history entry that becomes the PHT read index one cycle
//                later. A retiring branch returns its pre-update history as
//                the PHT write index and shifts its direction into the entry.
//                After reset an init sequence clears one entry per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module local_history_table #(
    parameter int LHT_ENTRIES = 1024,
    parameter int LOG_ENTRIES = 10,
    parameter int HIST_WIDTH  = 10,
    parameter int PC_WIDTH    = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  lht_rd_valid_i,
    input  logic [PC_WIDTH-1:0]   lht_rd_pc_i,
    output logic                  lht_hist_valid_o,
    output logic [HIST_WIDTH-1:0] lht_hist_o,
    input  logic                  lht_cm_we_i,
    input  logic [PC_WIDTH-1:0]   lht_cm_pc_i,
    input  logic                  lht_cm_brdir_i,
    output logic                  lht_cm_valid_o,
    output logic [HIST_WIDTH-1:0] lht_cm_index_o,
    output logic                  lht_busy_o
);

    localparam logic [LOG_ENTRIES-1:0] LAST_INDEX = LOG_ENTRIES'(LHT_ENTRIES - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [LOG_ENTRIES-1:0]  init_cnt;

    // History storage; cleared only through the init sequence.
    logic [HIST_WIDTH-1:0]   hist_mem [0:LHT_ENTRIES-1];

    logic [LOG_ENTRIES-1:0]  rd_index;
    logic [LOG_ENTRIES-1:0]  cm_index;
    logic [HIST_WIDTH-1:0]   rd_entry;
    logic [HIST_WIDTH-1:0]   cm_old;
    logic [HIST_WIDTH-1:0]   cm_new;
    logic                    running;
    logic                    do_rd;
    logic                    do_cm;

    assign rd_index = lht_rd_pc_i[LOG_ENTRIES+1:2];
    assign cm_index = lht_cm_pc_i[LOG_ENTRIES+1:2];
    assign rd_entry = hist_mem[rd_index];
    assign cm_old   = hist_mem[cm_index];
    assign cm_new   = {cm_old[HIST_WIDTH-2:0], lht_cm_brdir_i};

    // Requests only take effect once the table is cleared and reset is low.
    assign running  = (state == ST_RUN) && !reset;
    assign do_rd    = running && lht_rd_valid_i;
    assign do_cm    = running && lht_cm_we_i;

    // PC bits outside the index field are intentionally ignored (aliasing).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lht_rd_pc_i[PC_WIDTH-1:LOG_ENTRIES+2], lht_rd_pc_i[1:0],
                              lht_cm_pc_i[PC_WIDTH-1:LOG_ENTRIES+2], lht_cm_pc_i[1:0]};

    // Init/run control: sweep every entry once after reset, then stay in RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            lht_busy_o <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_INDEX) begin
                        state      <= ST_RUN;
                        lht_busy_o <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    lht_busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Table write port: init clear, else commit shift; nothing while in reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                hist_mem[init_cnt] <= '0;
            end else if (lht_cm_we_i) begin
                hist_mem[cm_index] <= cm_new;
            end
        end
    end

    // Lookup result register with write-first bypass from a same-index commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            lht_hist_valid_o <= 1'b0;
            lht_hist_o       <= '0;
        end else begin
            lht_hist_valid_o <= do_rd;
            if (do_rd) begin
                lht_hist_o <= (do_cm && (cm_index == rd_index)) ? cm_new : rd_entry;
            end
        end
    end

    // Commit result register: pre-update history becomes the PHT write index.
    always_ff @(posedge clock) begin
        if (reset) begin
            lht_cm_valid_o <= 1'b0;
            lht_cm_index_o <= '0;
        end else begin
            lht_cm_valid_o <= do_cm;
            if (do_cm) begin
                lht_cm_index_o <= cm_old;
            end
        end
    end

endmodule
`default_nettype wire
